output_buffer: RTL and testbench

//   CPU-to-IO store path: the counterpart of the memory-mapped input latch. CPU stores (byte/half/word at a

---
 rtl/output_buffer_pkg.sv | 43 ++++
 rtl/output_buffer_sync_fifo.sv | 73 +++++++
 rtl/output_buffer.sv | 92 +++++++++
 tb/tb_output_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_pkg.sv
// Shared store-width decode and lane helpers for the CPU-to-IO output buffer.
// Used by output_buffer (store merge and, with OUTPUT_BUFFER_READBACK_EN, readback).
package output_buffer_pkg;

  localparam logic [2:0] DT_BYTE  = 3'b000;
  localparam logic [2:0] DT_HALF  = 3'b001;
  localparam logic [2:0] DT_BYTEU = 3'b100;
  localparam logic [2:0] DT_HALFU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Signed and unsigned encodings share a width, so only the width is decoded here.
  function automatic size_e store_size(input logic [2:0] data_type);
    case (data_type)
      DT_BYTE, DT_BYTEU: return SZ_BYTE;
      DT_HALF, DT_HALFU: return SZ_HALF;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] lane_shift(input logic [2:0] data_type,
                                            input logic [1:0] data_offset);
    case (store_size(data_type))
      SZ_BYTE: return data_offset;
      SZ_HALF: return {data_offset[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] data_type,
                                           input logic [1:0] data_offset);
    case (store_size(data_type))
      SZ_BYTE: return 4'b0001 << lane_shift(data_type, data_offset);
      SZ_HALF: return 4'b0011 << lane_shift(data_type, data_offset);
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/output_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word that holds its last
// value while empty, so the consumer never sees stale storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign head    = head_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Head reloads from storage when a later entry exists, otherwise from the incoming word.
    if (do_pop && (count_q > CNT_ONE)) begin
      head_d = mem_q[rd_ptr_d];
    end else if (do_push && (empty || (do_pop && count_q == CNT_ONE))) begin
      head_d = push_data;
    end
  end

  // NOTE: storage carries no reset; only pointers, count and head define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/output_buffer.sv
// CPU store path into a shadow port register, queued to the IO side via valid/ready.
// Define OUTPUT_BUFFER_READBACK_EN to add the cpu_out shadow readback port.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        write,
  input  logic [2:0]  data_type,
  input  logic [1:0]  data_offset,
  input  logic [31:0] cpu_in,
  output logic        full,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [31:0] io_out,
  output logic        io_valid,
  input  logic        io_ready
`ifdef OUTPUT_BUFFER_READBACK_EN
  ,
  output logic [31:0] cpu_out
`endif
);

  logic [31:0] shadow_q, shadow_d;
  logic        overflow_q, overflow_d;
  logic [31:0] merged, shifted;
  logic [3:0]  mask;
  logic        pop, accept, fifo_empty;

  assign pop      = io_valid && io_ready;
  assign accept   = write && (!full || pop);
  assign io_valid = !fifo_empty;
  assign overflow = overflow_q;

  always_comb begin
    mask    = lane_mask(data_type, data_offset);
    shifted = cpu_in << {lane_shift(data_type, data_offset), 3'b000};
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : shadow_q[8*i +: 8];
    end
  end

  always_comb begin
    shadow_d   = accept ? merged : shadow_q;
    overflow_d = overflow_q;
    // A dropped store in the same cycle as a clear still leaves the flag set.
    if (write && !accept)  overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (accept),
    .push_data(merged),
    .pop      (pop),
    .full     (full),
    .empty    (fifo_empty),
    .head     (io_out)
  );

`ifdef OUTPUT_BUFFER_READBACK_EN
  logic [31:0] rb_shifted;

  always_comb begin
    rb_shifted = shadow_q >> {lane_shift(data_type, data_offset), 3'b000};
    case (data_type)
      DT_BYTE:  cpu_out = {{24{rb_shifted[7]}}, rb_shifted[7:0]};
      DT_BYTEU: cpu_out = {24'h0, rb_shifted[7:0]};
      DT_HALF:  cpu_out = {{16{rb_shifted[15]}}, rb_shifted[15:0]};
      DT_HALFU: cpu_out = {16'h0, rb_shifted[15:0]};
      default:  cpu_out = shadow_q;
    endcase
  end
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: a queue-based reference model predicts every
// delivered word; a negedge monitor compares outputs against it.
module tb_output_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  data_type = 3'b010;
  logic [1:0]  data_offset = 2'b00;
  logic [31:0] cpu_in = '0;
  logic        full, overflow, io_valid;
  logic        overflow_clr = 1'b0;
  logic        io_ready = 1'b0;
  logic [31:0] io_out;
`ifdef OUTPUT_BUFFER_READBACK_EN
  logic [31:0] cpu_out;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] shadow_m = '0;
  logic        ovf_m = 1'b0;
  logic [31:0] last_head = '0;
  logic        mon_en = 1'b0;

  always #5 clock = ~clock;

  output_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .write       (write),
    .data_type   (data_type),
    .data_offset (data_offset),
    .cpu_in      (cpu_in),
    .full        (full),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .io_out      (io_out),
    .io_valid    (io_valid),
    .io_ready    (io_ready)
`ifdef OUTPUT_BUFFER_READBACK_EN
    ,
    .cpu_out     (cpu_out)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference store: overwrite the addressed bytes of the shadow word.
  function automatic logic [31:0] model_merge(input logic [31:0] sh, input logic [2:0] dt,
                                              input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    m = sh;
    if (dt == 3'b000 || dt == 3'b100)      m[8*off +: 8] = d[7:0];
    else if (dt == 3'b001 || dt == 3'b101) m[16*off[1] +: 16] = d[15:0];
    else                                   m = d;
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] sh, input logic [2:0] dt,
                                             input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = sh[8*off +: 8];
    h = sh[16*off[1] +: 16];
    case (dt)
      3'b000:  return $signed(b);
      3'b100:  return {24'h0, b};
      3'b001:  return $signed(h);
      3'b101:  return {16'h0, h};
      default: return sh;
    endcase
  endfunction

  // One clock of stimulus; model state advances at the edge.
  task automatic step(input logic w, input logic [2:0] dt, input logic [1:0] off,
                      input logic [31:0] d, input logic rdy, input logic clr, input logic rst);
    logic        pop, acc;
    logic [31:0] merged;
    write = w; data_type = dt; data_offset = off; cpu_in = d;
    io_ready = rdy; overflow_clr = clr; reset_n = !rst;
    pop    = (exp_q.size() > 0) && rdy;
    acc    = w && ((exp_q.size() < DEPTH) || pop);
    merged = model_merge(shadow_m, dt, off, d);
    @(posedge clock);
    if (rst) begin
      exp_q.delete();
      shadow_m  = '0;
      ovf_m     = 1'b0;
      last_head = '0;
    end else begin
      if (acc) begin
        exp_q.push_back(merged);
        shadow_m = merged;
      end
      if (w && !acc) ovf_m = 1'b1;
      else if (clr)  ovf_m = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 3'b010, 2'b00, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic store(input logic [2:0] dt, input logic [1:0] off, input logic [31:0] d,
                       input logic rdy);
    step(1'b1, dt, off, d, rdy, 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin : monitor
    logic [31:0] exp_head;
    if (mon_en) begin
      exp_head = (exp_q.size() > 0) ? exp_q[0] : last_head;
      check("io_valid", {31'h0, io_valid}, {31'h0, exp_q.size() > 0});
      check("io_out", io_out, exp_head);
      check("full", {31'h0, full}, {31'h0, exp_q.size() == DEPTH});
      check("overflow", {31'h0, overflow}, {31'h0, ovf_m});
      if (exp_q.size() > 0) last_head = exp_q[0];
      if (io_valid && io_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    step(1'b0, 3'b010, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b010, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Reset then idle
    for (int i = 0; i < 10; i++) idle(1'b0);

    // Single word store, one-cycle latency, then drained
    store(3'b010, 2'b00, 32'hDEADBEEF, 1'b1);
    check("t2_valid", {31'h0, io_valid}, 32'h1);
    check("t2_out", io_out, 32'hDEADBEEF);
    idle(1'b1);
    check("t2_drained", {31'h0, io_valid}, 32'h0);

    // Byte and half merges onto a known shadow
    store(3'b010, 2'b00, 32'h11223344, 1'b1);
    store(3'b000, 2'b10, 32'h0000005A, 1'b1);
    check("t3_byte", io_out, 32'h115A3344);
    store(3'b001, 2'b11, 32'h0000ABCD, 1'b1);
    check("t3_half", io_out, 32'hABCD3344);
    idle(1'b1);

    // Fill with sink stalled, drop the fifth, drain in order, clear flag
    for (int i = 1; i <= 5; i++) begin
      store(3'b010, 2'b00, 32'(i), 1'b0);
      if (i == 4) check("t4_full", {31'h0, full}, 32'h1);
    end
    check("t4_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b0, 3'b010, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
    check("t4_clr", {31'h0, overflow}, 32'h0);

    // Full FIFO with simultaneous store and pop
    for (int i = 0; i < 4; i++) store(3'b010, 2'b00, 32'hA0 + 32'(i), 1'b0);
    store(3'b010, 2'b00, 32'hB0, 1'b1);
    check("t5_full", {31'h0, full}, 32'h1);
    check("t5_no_ovf", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset with queued entries
    for (int i = 0; i < 3; i++) store(3'b010, 2'b00, 32'hC0 + 32'(i), 1'b0);
    step(1'b0, 3'b010, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t6_valid", {31'h0, io_valid}, 32'h0);
    store(3'b000, 2'b01, 32'h000000EE, 1'b1);
    check("t6_shadow", io_out, 32'h0000EE00);
    idle(1'b1);

`ifdef OUTPUT_BUFFER_READBACK_EN
    store(3'b010, 2'b00, 32'h000080FF, 1'b1);
    data_type = 3'b000; data_offset = 2'b00; #1;
    check("rb_byte_sext", cpu_out, 32'hFFFFFFFF);
    data_type = 3'b101; data_offset = 2'b10; #1;
    check("rb_half_zext", cpu_out, 32'h00000000);
    idle(1'b1);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        w, rdy, clr, rst;
      logic [2:0]  dt;
      logic [1:0]  off;
      logic [31:0] d;
      w   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 99) < 2);
      dt  = 3'($urandom);
      off = 2'($urandom);
      d   = $urandom;
      step(w, dt, off, d, rdy, clr, rst);
`ifdef OUTPUT_BUFFER_READBACK_EN
      check("rb_random", cpu_out, model_load(shadow_m, data_type, data_offset));
`endif
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
